// File: rtl/jtag_dmi_master_pkg.sv
// Shared constants for the JTAG DMI initiator: TAP IR encoding, DMI op/status codes, FSM states.
package jtag_dmi_master_pkg;

   localparam int         IR_LEN          = 5;
   localparam logic [4:0] IR_DMI          = 5'h11;
   localparam int         TAP_RST_TMS_CNT = 5;

   localparam logic [1:0] DMI_OP_NOP   = 2'd0;
   localparam logic [1:0] DMI_OP_READ  = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE = 2'd2;

   localparam logic [1:0] DMI_ST_OK     = 2'd0;
   localparam logic [1:0] DMI_ST_FAILED = 2'd2;
   localparam logic [1:0] DMI_ST_BUSY   = 2'd3;

   localparam logic [2:0] S_TAP_RST = 3'd0;
   localparam logic [2:0] S_IR_SCAN = 3'd1;
   localparam logic [2:0] S_IDLE    = 3'd2;
   localparam logic [2:0] S_DR_REQ  = 3'd3;
   localparam logic [2:0] S_DR_RESP = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;

endpackage

// File: rtl/jtag_dmi_master_tck_gen.sv
// TCK divider: toggles TCK every TCK_DIV clk while enabled, with one-clk rise/fall strobes
// that are high in the first clk cycle of the new TCK level.
module jtag_tck_gen #(
   parameter int TCK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = $clog2(TCK_DIV);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         tck_o  <= 1'b0;
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
         if (!en) begin
            // parked low with a cleared divider so the next scan starts on a full half-period
            cnt   <= '0;
            tck_o <= 1'b0;
         end else if (cnt == CW'(TCK_DIV - 1)) begin
            cnt    <= '0;
            tck_o  <= ~tck_o;
            rise_o <= ~tck_o;
            fall_o <= tck_o;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/jtag_dmi_master.sv
// JTAG initiator driving a RISC-V DTM TAP: resets the TAP, selects DMI, then runs request/response DR scans.
// JTAG_MASTER_IR_RESCAN_EN: when defined, the DMI IR is rescanned after every response.
module jtag_dmi_master
   import jtag_dmi_master_pkg::*;
#(
   parameter int DMI_ADDR_BITS = 6,
   parameter int DMI_DATA_BITS = 32,
   parameter int DMI_OP_BITS   = 2,
   parameter int TCK_DIV       = 4,
   parameter int RETRY_MAX     = 15
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic                                              req_valid_i,
   output logic                                              req_ready_o,
   input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] req_data_i,
   output logic                                              resp_valid_o,
   input  logic                                              resp_ready_i,
   output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] resp_data_o,
   output logic                                              jtag_TCK_o,
   output logic                                              jtag_TMS_o,
   output logic                                              jtag_TDI_o,
   input  logic                                              jtag_TDO_i
);

   localparam int N  = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
   localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

   // TCK indices within each scan; TMS/TDI for index i are presented before rise i
   localparam logic [5:0] TAP_LAST    = 6'(TAP_RST_TMS_CNT);
   localparam logic [5:0] IR_SH_FIRST = 6'd4;
   localparam logic [5:0] IR_SH_LAST  = 6'(3 + IR_LEN);
   localparam logic [5:0] IR_LAST     = 6'(5 + IR_LEN);
   localparam logic [5:0] DR_SH_FIRST = 6'd3;
   localparam logic [5:0] DR_SH_LAST  = 6'(N + 2);
   localparam logic [5:0] DR_LAST     = 6'(N + 4);

   logic [2:0]    state;
   logic [5:0]    idx;
   logic [5:0]    last_idx;
   logic [N-1:0]  sr;
   logic [RW-1:0] retry;
   logic          tms, tdi;
   logic          tck_en, rise, fall;
   logic          dr_scan, dr_shift, busy;

   function automatic logic tms_at(logic [2:0] st, logic [5:0] i);
      logic r;
      r = 1'b0;
      case (st)
         S_TAP_RST:           r = (i < TAP_LAST);
         S_IR_SCAN:           r = (i < 6'd2) || (i == IR_SH_LAST) || (i == IR_SH_LAST + 6'd1);
         S_DR_REQ, S_DR_RESP: r = (i == 6'd0) || (i == DR_SH_LAST) || (i == DR_SH_LAST + 6'd1);
         default:             r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic tdi_at(logic [2:0] st, logic [5:0] i, logic sr0);
      logic r;
      r = 1'b0;
      if (st == S_IR_SCAN && i >= IR_SH_FIRST && i <= IR_SH_LAST)
         r = IR_DMI[3'(i - IR_SH_FIRST)];
      else if ((st == S_DR_REQ || st == S_DR_RESP) && i >= DR_SH_FIRST && i <= DR_SH_LAST)
         r = sr0;
      return r;
   endfunction

   assign tck_en       = (state != S_IDLE) && (state != S_RESP);
   assign dr_scan      = (state == S_DR_REQ) || (state == S_DR_RESP);
   assign dr_shift     = dr_scan && (idx >= DR_SH_FIRST) && (idx <= DR_SH_LAST);
   assign busy         = (sr[DMI_OP_BITS-1:0] == DMI_OP_BITS'(DMI_ST_BUSY));
   assign req_ready_o  = (state == S_IDLE);
   assign resp_valid_o = (state == S_RESP);
   assign jtag_TMS_o   = tms;
   assign jtag_TDI_o   = tdi;

   always_comb begin
      last_idx = DR_LAST;
      case (state)
         S_TAP_RST: last_idx = TAP_LAST;
         S_IR_SCAN: last_idx = IR_LAST;
         default:   last_idx = DR_LAST;
      endcase
   end

   jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (tck_en),
      .tck_o  (jtag_TCK_o),
      .rise_o (rise),
      .fall_o (fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_TAP_RST;
         idx         <= '0;
         sr          <= '0;
         retry       <= '0;
         tms         <= 1'b1;
         tdi         <= 1'b0;
         resp_data_o <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid_i) begin
                  sr    <= req_data_i;
                  retry <= '0;
                  idx   <= '0;
                  state <= S_DR_REQ;
                  tms   <= tms_at(S_DR_REQ, 6'd0);
                  tdi   <= 1'b0;
               end
            end
            S_RESP: begin
               if (resp_ready_i) begin
                  idx <= '0;
`ifdef JTAG_MASTER_IR_RESCAN_EN
                  state <= S_IR_SCAN;
                  tms   <= tms_at(S_IR_SCAN, 6'd0);
`else
                  state <= S_IDLE;
                  tms   <= 1'b0;
`endif
               end
            end
            default: begin
               // TDO is taken one clk after the TCK rise, well before the target changes it on the fall
               if (rise && dr_shift)
                  sr <= {jtag_TDO_i, sr[N-1:1]};
               if (fall) begin
                  if (idx == last_idx) begin
                     idx <= '0;
                     tdi <= 1'b0;
                     case (state)
                        S_TAP_RST: begin
                           state <= S_IR_SCAN;
                           tms   <= tms_at(S_IR_SCAN, 6'd0);
                        end
                        S_IR_SCAN: begin
                           state <= S_IDLE;
                           tms   <= 1'b0;
                        end
                        S_DR_REQ: begin
                           state <= S_DR_RESP;
                           sr    <= N'(DMI_OP_NOP);
                           tms   <= tms_at(S_DR_RESP, 6'd0);
                        end
                        default: begin
                           if (busy && retry < RW'(RETRY_MAX)) begin
                              retry <= retry + 1'b1;
                              sr    <= N'(DMI_OP_NOP);
                              tms   <= tms_at(S_DR_RESP, 6'd0);
                           end else begin
                              state       <= S_RESP;
                              resp_data_o <= sr;
                              tms         <= 1'b0;
                           end
                        end
                     endcase
                  end else begin
                     idx <= idx + 6'd1;
                     tms <= tms_at(state, idx + 6'd1);
                     tdi <= tdi_at(state, idx + 6'd1, sr[0]);
                  end
               end
            end
         endcase
      end
   end

endmodule
